// File: rtl/mp4_cpu.sv
// ---------------------------------------------------------------------------
// mp4_cpu
//   Multi-cycle, non-pipelined RV32I integer core. One instruction is in
//   flight at a time, so there is no hazard or forwarding logic. It has split
//   instruction and data ports, and each port talks to a single-word
//   request/response memory.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   inst_resp    instruction read complete, inst_rdata valid this cycle
//   inst_rdata   fetched instruction word
//   data_resp    data access complete, data_rdata valid this cycle (reads)
//   data_rdata   loaded word (aligned)
//   inst_read    fetch request, held until inst_resp
//   inst_addr    fetch address (= PC)
//   data_read    load request, held until data_resp
//   data_write   store request, held until data_resp
//   data_mbe     store byte enables (bit i = byte i), 4'b1111 on loads
//   data_addr    word address, bits [1:0] forced to zero
//   data_wdata   store data shifted into the addressed byte lanes
// ---------------------------------------------------------------------------
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_FETCH  | inst_read high until inst_resp; IR latched on the resp cycle
//   S_DECODE | read rs1/rs2 and build the sign-extended immediate
//   S_EXEC   | ALU / branch compare, next PC and effective address
//   S_MEM    | exactly one of data_read/data_write until data_resp
//   S_WB     | write rd (never x0), PC <= next PC
// ---------------------------------------------------------------------------
module mp4_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_resp,
    input  logic [31:0] inst_rdata,
    input  logic        data_resp,
    input  logic [31:0] data_rdata,
    output logic        inst_read,
    output logic [31:0] inst_addr,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_mbe,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] res_q;
    logic [31:0] npc_q;
    logic [31:0] mdr;
    logic [31:0] regs [1:31];

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    logic is_load;
    logic is_store;
    logic writes_rd;

    always_comb begin
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP: writes_rd = 1'b1;
            default:                     writes_rd = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file read (x0 always reads zero)
    // ------------------------------------------------------------------
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [31:0] imm;

    always_comb begin
        case (opcode)
            OPC_STORE:           imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:          imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25],
                                        ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:  imm = {ir[31:12], 12'd0};
            OPC_JAL:             imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20],
                                        ir[30:21], 1'b0};
            default:             imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // ------------------------------------------------------------------
    // ALU, branch compare, next PC
    // ------------------------------------------------------------------
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        alt;
    logic [31:0] alu_out;
    logic [31:0] result;
    logic [31:0] ea;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        taken;

    always_comb begin
        op_b     = (opcode == OPC_OP) ? rs2_q : imm_q;
        shamt    = op_b[4:0];
        // ir[30] selects SUB only for register ops (ADDI has no SUB form),
        // but selects SRA/SRAI for both shift encodings.
        alt      = ir[30];
        ea       = rs1_q + imm_q;
        pc_plus4 = pc + 32'd4;

        case (funct3)
            3'b000:  alu_out = (alt && opcode == OPC_OP) ? (rs1_q - op_b)
                                                          : (rs1_q + op_b);
            3'b001:  alu_out = rs1_q << shamt;
            3'b010:  alu_out = {31'd0, $signed(rs1_q) < $signed(op_b)};
            3'b011:  alu_out = {31'd0, rs1_q < op_b};
            3'b100:  alu_out = rs1_q ^ op_b;
            3'b101:  alu_out = alt ? 32'($signed(rs1_q) >>> shamt)
                                   : (rs1_q >> shamt);
            3'b110:  alu_out = rs1_q | op_b;
            default: alu_out = rs1_q & op_b;
        endcase

        case (funct3)
            3'b000:  taken = (rs1_q == rs2_q);
            3'b001:  taken = (rs1_q != rs2_q);
            3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  taken = (rs1_q <  rs2_q);
            3'b111:  taken = (rs1_q >= rs2_q);
            default: taken = 1'b0;
        endcase

        case (opcode)
            OPC_LUI:              result = imm_q;
            OPC_AUIPC:            result = pc + imm_q;
            OPC_JAL, OPC_JALR:    result = pc_plus4;
            OPC_LOAD, OPC_STORE:  result = ea;
            OPC_OPIMM, OPC_OP:    result = alu_out;
            default:              result = 32'd0;
        endcase

        case (opcode)
            OPC_JAL:     npc = pc + imm_q;
            OPC_JALR:    npc = ea & ~32'd1;
            OPC_BRANCH:  npc = taken ? (pc + imm_q) : pc_plus4;
            default:     npc = pc_plus4;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte-lane steering for stores and load extraction
    // ------------------------------------------------------------------
    logic [1:0]  off;
    logic [3:0]  st_mbe;
    logic [31:0] ld_shift;
    logic [31:0] ld_val;
    logic [31:0] wb_val;

    assign off = res_q[1:0];

    always_comb begin
        // Shifting within 4 bits drops lanes that fall past the word.
        case (funct3)
            3'b000:  st_mbe = 4'b0001 << off;
            3'b001:  st_mbe = 4'b0011 << off;
            default: st_mbe = 4'b1111;
        endcase

        ld_shift = mdr >> {off, 3'b000};
        case (funct3)
            3'b000:  ld_val = {{24{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {24'd0, ld_shift[7:0]};
            3'b101:  ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = mdr;
        endcase

        wb_val = is_load ? ld_val : res_q;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        case (state)
            S_FETCH: begin
                // The state register already sits in FETCH during reset, so
                // the request is masked until reset is released.
                inst_read = !reset;
                if (inst_resp) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                data_read  = is_load;
                data_write = is_store;
                if (data_resp) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign inst_addr  = pc;
    assign data_addr  = (state == S_MEM) ? {res_q[31:2], 2'b00} : 32'd0;
    assign data_mbe   = (state == S_MEM) ? (is_store ? st_mbe : 4'b1111) : 4'd0;
    assign data_wdata = (state == S_MEM && is_store) ? (rs2_q << {off, 3'b000})
                                                     : 32'd0;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            ir    <= 32'd0;
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
            imm_q <= 32'd0;
            res_q <= 32'd0;
            npc_q <= 32'd0;
            mdr   <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (inst_resp) begin
                        ir <= inst_rdata;
                    end
                end
                S_DECODE: begin
                    rs1_q <= rs1_val;
                    rs2_q <= rs2_val;
                    imm_q <= imm;
                end
                S_EXEC: begin
                    res_q <= result;
                    npc_q <= npc;
                end
                S_MEM: begin
                    if (data_resp && is_load) begin
                        mdr <= data_rdata;
                    end
                end
                S_WB: begin
                    if (writes_rd && rd != 5'd0) begin
                        regs[rd] <= wb_val;
                    end
                    pc <= npc_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp4_cpu.sv
// ---------------------------------------------------------------------------
// tb_mp4_cpu
//   Directed program bench for mp4_cpu. A behavioural instruction/data memory
//   answers the handshakes with address-dependent latency. Register results
//   are observed through stores and compared with a hand-computed store list.
// ---------------------------------------------------------------------------
module tb_mp4_cpu;

    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    mp4_cpu #(.RESET_PC(32'h0000_0060)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .data_resp  (data_resp),
        .data_rdata (data_rdata),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:1023];
    logic [31:0] ex_a [$];
    logic [3:0]  ex_m [$];
    logic [31:0] ex_d [$];
    logic [31:0] fetch_q [$];
    logic [31:0] pc_b;
    logic [31:0] last_fetch = 32'hFFFF_FFFF;
    int          loop_cnt = 0;
    int          ns = 0;
    int          viol = 0;
    int          stab = 0;
    int          iwait = 0;
    int          dwait = 0;
    logic        prev_iresp = 1'b0;
    logic        prev_dresp = 1'b0;
    logic        hold_rd = 1'b0;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_mbe;
    logic [1:0]  snap_rw;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- assembler helpers ----------------
    function automatic logic [31:0] ei(input int imm, input int rs1, input int f3,
                                       input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] er(input int f7, input int rs2, input int rs1,
                                       input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
    endfunction

    function automatic logic [31:0] es(input int imm, input int rs2, input int rs1,
                                       input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], ST};
    endfunction

    function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1,
                                       input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [31:0] eu(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] ej(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JAL};
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[pc_b[11:2]] = w;
        pc_b = pc_b + 32'd4;
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        ex_a.push_back(a);
        ex_m.push_back(m);
        ex_d.push_back(d);
    endtask

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        if (reset) begin
            // Responses held high through reset; the core must ignore them.
            inst_resp  = 1'b1;
            data_resp  = 1'b1;
            iwait      = 0;
            dwait      = 0;
            prev_iresp = 1'b0;
            prev_dresp = 1'b0;
        end else begin
            if (inst_read && (data_read || data_write)) viol++;
            if (data_read && data_write) viol++;
            if (prev_dresp && (data_read || data_write)) viol++;
            if (prev_iresp && inst_read) viol++;
            inst_resp = 1'b0;
            data_resp = 1'b0;

            if (inst_read) begin
                if (iwait >= int'((inst_addr >> 2) % 3)) begin
                    inst_resp  = 1'b1;
                    inst_rdata = imem[inst_addr[11:2]];
                    fetch_q.push_back(inst_addr);
                    if (inst_addr == last_fetch) loop_cnt++;
                    else loop_cnt = 0;
                    last_fetch = inst_addr;
                    iwait = 0;
                end else begin
                    iwait++;
                end
            end else begin
                iwait = 0;
            end

            if (data_read || data_write) begin
                if (dwait == 0) begin
                    snap_addr  = data_addr;
                    snap_wdata = data_wdata;
                    snap_mbe   = data_mbe;
                    snap_rw    = {data_read, data_write};
                end else if (snap_addr !== data_addr || snap_wdata !== data_wdata ||
                             snap_mbe !== data_mbe || snap_rw !== {data_read, data_write}) begin
                    stab++;
                end
                if (data_read && data_mbe !== 4'hF) viol++;
                if (data_addr[1:0] !== 2'b00) viol++;
                if (!(data_read && hold_rd) &&
                    dwait >= ((data_addr == 32'h100) ? 5 : 0)) begin
                    data_resp = 1'b1;
                    if (data_read) begin
                        data_rdata = dmem[data_addr[11:2]];
                    end else begin
                        if (ns < ex_a.size()) begin
                            chk($sformatf("st%0d_addr", ns), data_addr, ex_a[ns]);
                            chk($sformatf("st%0d_mbe", ns), {28'd0, data_mbe}, {28'd0, ex_m[ns]});
                            chk($sformatf("st%0d_data", ns), data_wdata, ex_d[ns]);
                        end else begin
                            chk("st_extra", ns, ex_a.size());
                        end
                        ns++;
                        for (int b = 0; b < 4; b++) begin
                            if (data_mbe[b]) dmem[data_addr[11:2]][8*b +: 8] = data_wdata[8*b +: 8];
                        end
                    end
                    dwait = 0;
                end else begin
                    dwait++;
                end
            end else begin
                dwait = 0;
            end
            prev_iresp = inst_resp;
            prev_dresp = data_resp;
        end
    end

    // ---------------- stimulus ----------------
    int          sr [18] = '{8, 9, 10, 11, 13, 14, 15, 16, 17, 18, 19, 20, 21, 0, 31, 24, 25, 26};
    logic [31:0] sv [18] = '{32'h5544_3423, 32'h1, 32'h0, 32'hFAAB_BCCD, 32'h0AAB_BCCD,
                             32'hABBC_CDD0, 32'hAABB_CDDD, 32'hFFAA_BBCC, 32'h1, 32'h0,
                             32'hD0, 32'hFFFF_F900, 32'h0000_10E8, 32'h0, 32'h0,
                             32'h7, 32'h3, 32'h4};

    initial begin
        reset      = 1'b1;
        inst_resp  = 1'b1;
        data_resp  = 1'b0;
        inst_rdata = 32'd0;
        data_rdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'd0;
        end
        dmem[32'h100 >> 2] = 32'h8000_0080;

        // main straight-line block
        pc_b = 32'h60;
        emit(ei(5, 0, 0, 1, OPI));
        emit(ei(-7, 1, 0, 2, OPI));
        emit(es(32'h200, 1, 0, 2));        exp_st(32'h200, 4'hF, 32'h5);
        emit(es(32'h204, 2, 0, 2));        exp_st(32'h204, 4'hF, 32'hFFFF_FFFE);
        emit(ei(32'h100, 0, 0, 1, OPI));
        emit(eu(32'hAABBD, 2, LUI));
        emit(ei(-803, 2, 0, 2, OPI));
        emit(ei(3, 1, 0, 3, LD));          // lb
        emit(ei(2, 1, 5, 4, LD));          // lhu
        emit(ei(2, 1, 1, 5, LD));          // lh
        emit(ei(0, 1, 4, 6, LD));          // lbu
        emit(ei(0, 1, 2, 7, LD));          // lw
        emit(es(32'h208, 3, 0, 2));        exp_st(32'h208, 4'hF, 32'hFFFF_FF80);
        emit(es(32'h20C, 4, 0, 2));        exp_st(32'h20C, 4'hF, 32'h0000_8000);
        emit(es(32'h210, 5, 0, 2));        exp_st(32'h210, 4'hF, 32'hFFFF_8000);
        emit(es(32'h214, 6, 0, 2));        exp_st(32'h214, 4'hF, 32'h0000_0080);
        emit(es(32'h218, 7, 0, 2));        exp_st(32'h218, 4'hF, 32'h8000_0080);
        emit(es(3, 2, 1, 0));              exp_st(32'h100, 4'b1000, 32'hDD00_0000);
        emit(es(3, 2, 1, 1));              exp_st(32'h100, 4'b1000, 32'hDD00_0000);
        emit(es(2, 2, 1, 1));              exp_st(32'h100, 4'b1100, 32'hCCDD_0000);
        emit(es(1, 2, 1, 0));              exp_st(32'h100, 4'b0010, 32'hBBCC_DD00);
        emit(er(32'h20, 2, 1, 0, 8));      // sub
        emit(er(0, 1, 2, 2, 9));           // slt
        emit(er(0, 1, 2, 3, 10));          // sltu
        emit(ei(36, 0, 0, 12, OPI));
        emit(er(32'h20, 12, 2, 5, 11));    // sra
        emit(er(0, 12, 2, 5, 13));         // srl
        emit(er(0, 12, 2, 1, 14));         // sll
        emit(er(0, 1, 2, 4, 15));          // xor
        emit(ei(32'h408, 2, 5, 16, OPI));  // srai 8
        emit(ei(-1, 1, 3, 17, OPI));       // sltiu
        emit(ei(-1, 1, 2, 18, OPI));       // slti
        emit(ei(32'hF0, 2, 7, 19, OPI));   // andi
        emit(ei(-2048, 1, 6, 20, OPI));    // ori
        emit(eu(1, 21, AUI));              // at 0xE8
        emit(ei(5, 0, 0, 0, OPI));         // write to x0
        emit(32'hFFFF_FFFF);               // unknown opcode, rd=x31
        emit(32'h0000_000F);               // fence
        emit(ej(32'h108, 22));             // at 0xF8 -> 0x200
        emit(ei(1, 0, 0, 23, OPI));        // skipped

        // branch block
        pc_b = 32'h200;
        emit(ei(7, 0, 0, 24, OPI));
        emit(eb(8, 1, 2, 4));              // blt x2,x1 taken
        emit(ei(1, 0, 0, 24, OPI));
        emit(eb(8, 1, 2, 6));              // bltu x2,x1 not taken
        emit(ei(3, 0, 0, 25, OPI));
        emit(eb(8, 2, 1, 5));              // bge x1,x2 taken
        emit(ei(9, 0, 0, 25, OPI));
        emit(eb(8, 1, 1, 1));              // bne x1,x1 not taken
        emit(ei(4, 0, 0, 26, OPI));
        for (int k = 0; k < 18; k++) begin
            emit(es(32'h220 + 4 * k, sr[k], 0, 2));
            exp_st(32'h220 + 32'(4 * k), 4'hF, sv[k]);
        end
        emit(ei(1, 1, 0, 5, JALR));        // at 0x26C -> 0x100

        // jalr target block, ends in a self-loop
        pc_b = 32'h100;
        emit(es(32'h268, 5, 0, 2));        exp_st(32'h268, 4'hF, 32'h270);
        emit(es(32'h26C, 22, 0, 2));       exp_st(32'h26C, 4'hF, 32'hFC);
        emit(es(32'h270, 23, 0, 2));       exp_st(32'h270, 4'hF, 32'h0);
        emit(eb(0, 0, 0, 0));              // beq x0,x0,0

        #1;
        chk("rst_inst_read", {31'd0, inst_read}, 32'd0);
        chk("rst_inst_addr", inst_addr, 32'h60);
        chk("rst_data_read", {31'd0, data_read}, 32'd0);
        chk("rst_data_write", {31'd0, data_write}, 32'd0);
        chk("rst_data_mbe", {28'd0, data_mbe}, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_data_wdata", data_wdata, 32'd0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("c1_inst_read", {31'd0, inst_read}, 32'd1);
        chk("c1_inst_addr", inst_addr, 32'h60);
        chk("c1_data_rw", {30'd0, data_read, data_write}, 32'd0);

        for (int c = 0; c < 6000 && loop_cnt < 3; c++) @(posedge clk);
        chk("p1_selfloop", {31'd0, loop_cnt >= 3}, 32'd1);
        chk("p1_loop_pc", last_fetch, 32'h10C);
        chk("p1_fetch0", fetch_q[0], 32'h60);
        chk("p1_fetch1", fetch_q[1], 32'h64);
        chk("p1_nstores", ns, 32);

        // phase 2: registers cleared by reset, then reset during a stalled load
        @(negedge clk);
        #2 reset = 1'b1;
        imem[32'h60 >> 2] = es(32'h300, 1, 0, 2);
        imem[32'h64 >> 2] = ei(32'h100, 0, 2, 3, LD);
        exp_st(32'h300, 4'hF, 32'h0);
        exp_st(32'h300, 4'hF, 32'h0);
        hold_rd = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < 200 && !data_read; c++) @(negedge clk);
        chk("p2_ld_req", {31'd0, data_read}, 32'd1);
        chk("p2_ld_addr", data_addr, 32'h100);
        repeat (4) @(negedge clk);
        chk("p2_ld_held", {31'd0, data_read}, 32'd1);
        chk("p2_ld_noinst", {31'd0, inst_read}, 32'd0);
        chk("p2_nstores", ns, 33);
        #2 reset = 1'b1;
        #1;
        chk("mid_inst_read", {31'd0, inst_read}, 32'd0);
        chk("mid_inst_addr", inst_addr, 32'h60);
        chk("mid_data_rw", {30'd0, data_read, data_write}, 32'd0);
        chk("mid_data_mbe", {28'd0, data_mbe}, 32'd0);
        chk("mid_data_addr", data_addr, 32'd0);
        chk("mid_data_wdata", data_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("c1b_inst_read", {31'd0, inst_read}, 32'd1);
        chk("c1b_inst_addr", inst_addr, 32'h60);
        for (int c = 0; c < 200 && ns < 34; c++) @(posedge clk);
        chk("p3_nstores", ns, 34);

        chk("handshake_viol", viol, 0);
        chk("stable_viol", stab, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
